// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared state type and default parameters for bus_arbiter
package bus_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_NUM_MASTERS = 4;
    localparam int DEF_TIMEOUT     = 64;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - combinational round-robin pick: first set req bit at or after ptr
module rr_pick import bus_arbiter_pkg::*; #(
    parameter int p_num_masters = DEF_NUM_MASTERS,
    parameter int p_idx_w       = $clog2(p_num_masters)
) (
    input  logic [p_num_masters-1:0] req,
    input  logic [p_idx_w-1:0]       ptr,
    output logic                     valid,
    output logic [p_idx_w-1:0]       index
);

    localparam int                 p_sum_w = p_idx_w + 1;
    localparam logic [p_sum_w-1:0] c_n     = p_sum_w'(p_num_masters);

    logic [p_sum_w-1:0] pos;

    always_comb begin
        valid = 1'b0;
        index = '0;
        pos   = '0;
        // Scan from the farthest slot back toward ptr so the nearest requester writes last.
        for (int k = p_num_masters - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + p_sum_w'(k);
            if (pos >= c_n) begin
                pos = pos - c_n;
            end
            if (req[pos[p_idx_w-1:0]]) begin
                valid = 1'b1;
                index = pos[p_idx_w-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter for a shared OR-bus; BUS_ARBITER_TIMEOUT_EN adds forced release
module bus_arbiter import bus_arbiter_pkg::*; #(
    parameter int p_data_width  = DEF_DATA_WIDTH,
    parameter int p_num_masters = DEF_NUM_MASTERS,
    parameter int p_timeout     = DEF_TIMEOUT
) (
    input  logic                                  i_w_clk,
    input  logic                                  i_w_reset,
    input  logic [p_num_masters-1:0]              i_w_req,
    input  logic [p_num_masters-1:0]              i_w_done,
    input  logic [p_num_masters*p_data_width-1:0] i_w_data,
    output logic [p_num_masters-1:0]              o_w_grant,
    output logic [$clog2(p_num_masters)-1:0]      o_w_owner,
    output logic                                  o_w_busy,
    output logic [p_data_width-1:0]               o_w_bus,
    output logic                                  o_w_timeout
);

    localparam int                       p_idx_w = $clog2(p_num_masters);
    localparam logic [p_idx_w-1:0]       c_last  = p_idx_w'(p_num_masters - 1);
    localparam logic [p_num_masters-1:0] c_one   = p_num_masters'(1);

    arb_state_t               state;
    arb_state_t               state_nxt;
    logic [p_idx_w-1:0]       rr_ptr;
    logic [p_idx_w-1:0]       ptr_nxt;
    logic [p_idx_w-1:0]       owner_nxt;
    logic [p_idx_w-1:0]       pick_idx;
    logic [p_num_masters-1:0] grant_nxt;
    logic                     busy_nxt;
    logic                     pick_valid;
    logic                     owner_release;
    logic [p_data_width-1:0]  words [p_num_masters];

    rr_pick #(
        .p_num_masters (p_num_masters),
        .p_idx_w       (p_idx_w)
    ) u_rr_pick (
        .req   (i_w_req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .index (pick_idx)
    );

    for (genvar k = 0; k < p_num_masters; k++) begin : g_words
        assign words[k] = i_w_data[k*p_data_width +: p_data_width];
    end

    // Only the owner's own strobes matter; everyone else is ignored while OWNED.
    assign owner_release = i_w_done[o_w_owner] | ~i_w_req[o_w_owner];

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int                 p_cnt_w    = $clog2(p_timeout + 1);
    localparam logic [p_cnt_w-1:0] c_tmo_last = p_cnt_w'(p_timeout - 1);

    logic [p_cnt_w-1:0] tmo_cnt;
    logic               tmo_hit;
    logic               timeout_nxt;

    assign tmo_hit = (tmo_cnt == c_tmo_last);

    // tmo_cnt holds the number of OWNED cycles already completed by the current owner.
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            tmo_cnt     <= '0;
            o_w_timeout <= 1'b0;
        end else begin
            o_w_timeout <= timeout_nxt;
            if (state == OWNED && state_nxt == OWNED) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = |p_timeout;
    assign o_w_timeout    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = '0;
        owner_nxt = o_w_owner;
        busy_nxt  = 1'b0;
        ptr_nxt   = rr_ptr;
`ifdef BUS_ARBITER_TIMEOUT_EN
        timeout_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = OWNED;
                    grant_nxt = c_one << pick_idx;
                    owner_nxt = pick_idx;
                    busy_nxt  = 1'b1;
                    ptr_nxt   = (pick_idx == c_last) ? '0 : pick_idx + 1'b1;
                end
            end
            OWNED: begin
                grant_nxt = o_w_grant;
                busy_nxt  = 1'b1;
                if (owner_release) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    busy_nxt  = 1'b0;
                end
`ifdef BUS_ARBITER_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_nxt   = IDLE;
                    grant_nxt   = '0;
                    busy_nxt    = 1'b0;
                    timeout_nxt = 1'b1;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            o_w_grant <= '0;
            o_w_owner <= '0;
            o_w_busy  <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= ptr_nxt;
            o_w_grant <= grant_nxt;
            o_w_owner <= owner_nxt;
            o_w_busy  <= busy_nxt;
        end
    end

    // Idle sources must drive zero onto the OR-bus.
    always_comb begin
        o_w_bus = '0;
        if (o_w_busy) begin
            o_w_bus = words[o_w_owner];
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter with a behavioural round-robin model
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 8;

    logic           clk  = 1'b0;
    logic           rst  = 1'b1;
    logic [N-1:0]   req  = '0;
    logic [N-1:0]   done = '0;
    logic [N*W-1:0] data = '0;
    logic [N-1:0]   grant;
    logic [1:0]     owner;
    logic           busy;
    logic [W-1:0]   bus;
    logic           tmo;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    bit m_owned = 1'b0;
    bit m_to    = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int m_pick  = 0;

    int order [5] = '{0, 1, 2, 3, 0};

    bus_arbiter #(
        .p_data_width  (W),
        .p_num_masters (N),
        .p_timeout     (TO)
    ) dut (
        .i_w_clk     (clk),
        .i_w_reset   (rst),
        .i_w_req     (req),
        .i_w_done    (done),
        .i_w_data    (data),
        .o_w_grant   (grant),
        .o_w_owner   (owner),
        .o_w_busy    (busy),
        .o_w_bus     (bus),
        .o_w_timeout (tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        req  = '0;
        done = '0;
        @(negedge clk);
        rst  = 1'b0;
    endtask

    // Reference: a bus owner holds until it releases; an idle bus goes to the nearest requester after the pointer.
    always @(posedge clk) begin
        if (rst) begin
            m_owned = 1'b0;
            m_owner = 0;
            m_ptr   = 0;
            m_cnt   = 0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (!m_owned) begin
                m_pick = -1;
                for (int k = 0; k < N; k++) begin
                    if (m_pick < 0 && req[(m_ptr + k) % N]) m_pick = (m_ptr + k) % N;
                end
                if (m_pick >= 0) begin
                    m_owned = 1'b1;
                    m_owner = m_pick;
                    m_ptr   = (m_pick + 1) % N;
                    m_cnt   = 0;
                end
            end else begin
                m_cnt++;
                if (done[m_owner] || !req[m_owner]) begin
                    m_owned = 1'b0;
                end
`ifdef BUS_ARBITER_TIMEOUT_EN
                else if (m_cnt >= TO) begin
                    m_owned = 1'b0;
                    m_to    = 1'b1;
                end
`endif
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("grant",  grant, m_owned ? (32'd1 << m_owner) : 32'd0);
            check("owner",  owner, m_owner);
            check("busy",   busy,  m_owned);
            check("bus",    bus,   m_owned ? data[m_owner*W +: W] : 16'd0);
            check("tmo",    tmo,   m_to);
            check("onehot", ($countones(grant) <= 1), 1);
        end
    end

    initial begin
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_grant", grant, 0);
        check("rst_busy",  busy,  0);
        check("rst_owner", owner, 0);
        check("rst_bus",   bus,   0);
        check("rst_tmo",   tmo,   0);
        rst = 1'b0;

        // Single requester: grant one cycle after request.
        data = {$urandom, $urandom};
        data[2*W +: W] = 16'hA5A5;
        req = 4'b0100;
        tick();
        check("s1_grant", grant, 4'b0100);
        check("s1_owner", owner, 2);
        check("s1_bus",   bus,   16'hA5A5);

        // All requesting: rotation with an idle gap between owners.
        do_reset();
        data = 64'h1111_2222_3333_4444;
        req  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_grant", grant, 32'd1 << order[i]);
            check("rr_owner", owner, order[i]);
            @(negedge clk);
            done = 4'b1111;
            tick();
            check("rr_gap_grant", grant, 0);
            check("rr_gap_busy",  busy,  0);
            check("rr_gap_bus",   bus,   0);
            @(negedge clk);
            done = '0;
        end

        // Non-owner strobes are ignored.
        do_reset();
        req = 4'b1000;
        tick();
        check("no_grant3", grant, 4'b1000);
        @(negedge clk);
        req  = 4'b1011;
        done = 4'b0010;
        tick();
        check("no_hold1", grant, 4'b1000);
        @(negedge clk);
        req  = 4'b1010;
        done = '0;
        tick();
        check("no_hold2", grant, 4'b1000);
        check("no_owner", owner, 3);

        // Reset mid-ownership drops the grant and rewinds the pointer.
        do_reset();
        data = {$urandom, $urandom};
        req  = 4'b0010;
        tick();
        check("rs_owner", owner, 1);
        check("rs_busy",  busy,  1);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("rs_grant0", grant, 0);
        check("rs_busy0",  busy,  0);
        check("rs_bus0",   bus,   0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        tick();
        check("rs_ptr0", grant, 4'b0001);

        // Single master holding the bus without releasing.
        do_reset();
        req = 4'b0001;
        tick();
        check("to_grant", grant, 4'b0001);
`ifdef BUS_ARBITER_TIMEOUT_EN
        for (int i = 1; i < TO; i++) begin
            tick();
            check("to_busy", busy, 1);
            check("to_quiet", tmo, 0);
        end
        tick();
        check("to_drop", busy, 0);
        check("to_pulse", tmo, 1);
        tick();
        check("to_regrant", grant, 4'b0001);
        check("to_clear", tmo, 0);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_busy", busy, 1);
            check("hold_tmo",  tmo,  0);
        end
`endif

        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 39) == 0);
            req  = N'($urandom);
            done = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            data = {$urandom, $urandom};
        end
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < N; k++) req[k] = ($urandom_range(0, 7) != 0);
            done = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
            data = {$urandom, $urandom};
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
